// File: rtl/rc_ramp_control_voltage_if.sv
// Sample-strobe / gate / control-voltage bundle for rc_ramp_control_voltage.
//   audio_clk_en : one-cycle sample strobe
//   gate         : 1 = charge toward V_HIGH, 0 = discharge toward V_LOW
//   v_control    : signed 16-bit control voltage (VCC = 1<<SIGNAL_FRACTION_WIDTH)
//   busy         : multiply/update in progress
//   overrun      : strobe arrived while busy (sample dropped)
// master = stimulus side, slave = the ramp block.
interface rc_ramp_control_voltage_if;
  logic               audio_clk_en;
  logic               gate;
  logic signed [15:0] v_control;
  logic               busy;
  logic               overrun;

  modport master (output audio_clk_en, gate, input v_control, busy, overrun);
  modport slave  (input audio_clk_en, gate, output v_control, busy, overrun);
endinterface

// File: rtl/rc_ramp_control_voltage.sv
// RC charge/discharge model of the 555 VCO control-voltage capacitor.
// Each accepted audio sample moves the output a fraction alpha of the way
// toward the gate-selected target; alpha*|err| comes from a 24-cycle
// LSB-first shift-add multiplier, so one update takes 26 clocks.
// Ports:
//   clk    : system clock
//   I_RSTn : asynchronous active-low reset
//   bus    : rc_ramp_control_voltage_if.slave (audio_clk_en, gate in;
//            v_control, busy, overrun out)
// Optional feature macro RC_RAMP_SNAP_EN: when the output is within
// SNAP_THRESHOLD LSB of the target, the update lands exactly on it.
module rc_ramp_control_voltage #(
  parameter int  SIGNAL_FRACTION_WIDTH = 14,
  parameter real VCC                   = 12.0,
  parameter real SAMPLE_RATE           = 48e3,
  parameter real V_HIGH                = 4.0,
  parameter real V_LOW                 = 0.0,
  parameter real R_CHARGE              = 47e3,
  parameter real R_DISCHARGE           = 10e3,
  parameter real C                     = 3.3e-6
`ifdef RC_RAMP_SNAP_EN
  , parameter int SNAP_THRESHOLD       = 4
`endif
) (
  input logic                       clk,
  input logic                       I_RSTn,
  rc_ramp_control_voltage_if.slave  bus
);

  // Per-sample approach fraction in Q0.24, clamped so a step always moves
  // and never exceeds the remaining error.
  function automatic logic [23:0] calc_alpha(input real tau_samples);
    real a;
    a = 16777216.0 * (1.0 - $exp(-1.0 / tau_samples));
    if (a < 1.0)               calc_alpha = 24'd1;
    else if (a >= 16777215.0)  calc_alpha = 24'hFF_FFFF;
    else                       calc_alpha = 24'($rtoi(a));
  endfunction

  localparam real SIGNAL_MULTIPLIER = real'(1 << SIGNAL_FRACTION_WIDTH);
  localparam logic signed [15:0] SIG_HIGH = 16'($rtoi(SIGNAL_MULTIPLIER * V_HIGH / VCC));
  localparam logic signed [15:0] SIG_LOW  = 16'($rtoi(SIGNAL_MULTIPLIER * V_LOW  / VCC));
  localparam logic [23:0] ALPHA_C = calc_alpha(R_CHARGE    * C * SAMPLE_RATE);
  localparam logic [23:0] ALPHA_D = calc_alpha(R_DISCHARGE * C * SAMPLE_RATE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_UPD  = 2'd2;

  logic [1:0]         state;
  logic [4:0]         cnt;
  logic signed [31:0] acc;        // voltage with 16 extra fraction bits
  logic               gate_q;
  logic               err_neg;
  logic [31:0]        mag;        // |err|
  logic [55:0]        prod;       // {partial sum, remaining alpha bits}

  logic signed [15:0] target_nx;
  logic [23:0]        alpha_nx;
  logic signed [32:0] err;
  logic [31:0]        err_abs;
  logic [32:0]        sum;
  logic [31:0]        step;
  logic signed [31:0] acc_nx;

  assign target_nx = gate_q ? SIG_HIGH : SIG_LOW;
  assign alpha_nx  = gate_q ? ALPHA_C  : ALPHA_D;
  assign err       = {target_nx[15], target_nx, 16'd0} - {acc[31], acc};
  assign err_abs   = err[32] ? 32'(-err) : err[31:0];

  // Multiplier bits live in prod's low half and are consumed from bit 0;
  // the partial sum enters from the top as the register shifts right, so
  // after 24 shifts prod holds the full 56-bit mag*alpha.
  assign sum  = {1'b0, prod[55:24]} + {1'b0, (prod[0] ? mag : 32'd0)};
  assign step = prod[55:24];      // floor(|err|*alpha / 2^24) <= |err|

`ifdef RC_RAMP_SNAP_EN
  localparam logic signed [16:0] SNAP_T = 17'(SNAP_THRESHOLD);
  logic signed [15:0] target_q;
  logic signed [16:0] snap_diff;
  logic               snap;
  assign snap_diff = {target_q[15], target_q} - {acc[31], acc[31:16]};
  assign snap      = (snap_diff <= SNAP_T) && (snap_diff >= -SNAP_T);
`endif

  always_comb begin
    acc_nx = err_neg ? (acc - step) : (acc + step);
`ifdef RC_RAMP_SNAP_EN
    if (snap) acc_nx = {target_q, 16'd0};
`endif
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= {SIG_LOW, 16'd0};
      gate_q  <= 1'b0;
      err_neg <= 1'b0;
      mag     <= '0;
      prod    <= '0;
`ifdef RC_RAMP_SNAP_EN
      target_q <= SIG_LOW;
`endif
    end else begin
      gate_q <= bus.gate;
      case (state)
        S_IDLE: if (bus.audio_clk_en) begin
          err_neg <= err[32];
          mag     <= err_abs;
          prod    <= {32'd0, alpha_nx};
          cnt     <= '0;
`ifdef RC_RAMP_SNAP_EN
          target_q <= target_nx;
`endif
          state   <= S_MUL;
        end
        S_MUL: begin
          prod <= {sum, prod[23:1]};
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd23) state <= S_UPD;
        end
        S_UPD: begin
          acc   <= acc_nx;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.v_control = acc[31:16];
  assign bus.busy      = (state != S_IDLE);
  // Strobes outside IDLE are dropped; flag them in the same cycle.
  assign bus.overrun   = bus.audio_clk_en & (state != S_IDLE);

endmodule

// File: tb/tb_rc_ramp_control_voltage.sv
module tb_rc_ramp_control_voltage;
  // Shortened time constant keeps full settling within the cycle budget.
  localparam real C_TB   = 1.65e-8;
  localparam real VCC_TB = 12.0;
  localparam real FS_TB  = 48e3;
  localparam real VH_TB  = 4.0;
  localparam real VL_TB  = 0.0;
  localparam real RC_TB  = 47e3;
  localparam real RD_TB  = 10e3;
  localparam int  SNAP_TB = 4;

  localparam int EV_NONE = 0;
  localparam int EV_GATE = 1;
  localparam int EV_OVR  = 2;
  localparam int EV_RST  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  longint cyc = 0;

  rc_ramp_control_voltage_if bus();

  rc_ramp_control_voltage #(.C(C_TB)) dut (
    .clk    (clk),
    .I_RSTn (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  longint sig_high, sig_low, alpha_c, alpha_d;
  longint macc;

  typedef struct { longint due; longint val; } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic longint alpha_of(input real r);
    real a;
    a = 16777216.0 * (1.0 - $exp(-1.0 / (r * C_TB * FS_TB)));
    if (a < 1.0) return 1;
    if (a >= 16777215.0) return 64'd16777215;
    return longint'($rtoi(a));
  endfunction

  // One sample of the RC law: move alpha/2^24 of the remaining error,
  // truncating the step toward zero.
  function automatic longint model_update(input longint a, input bit g);
    longint tgt, err, mag, step, nxt;
    tgt  = g ? sig_high : sig_low;
    err  = tgt * 65536 - a;
    mag  = (err < 0) ? -err : err;
    step = (mag * (g ? alpha_c : alpha_d)) / 16777216;
    nxt  = (err < 0) ? a - step : a + step;
`ifdef RC_RAMP_SNAP_EN
    if (((tgt - (a >>> 16)) <= SNAP_TB) && ((tgt - (a >>> 16)) >= -SNAP_TB)) nxt = tgt * 65536;
`endif
    return nxt;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: each accepted sample must show busy in its last
  // busy cycle and the new voltage exactly 26 clocks after acceptance.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      if (cyc == sbq[0].due - 1) begin
        chk("busy_before_update", longint'(bus.busy), 1);
      end else if (cyc == sbq[0].due) begin
        chk("v_control_update", longint'(bus.v_control), sbq[0].val);
        chk("busy_after_update", longint'(bus.busy), 0);
        sbq.delete(0);
      end
    end
  end

  // Issue one strobe from idle and follow it for 26 clocks, optionally
  // perturbing it at offset ev_at.
  task automatic strobe(input int ev_at, input int ev);
    longint k;
    exp_t e;
    k = cyc;
    bus.audio_clk_en = 1'b1;
    macc = model_update(macc, bus.gate);
    e.due = k + 26;
    e.val = macc >>> 16;
    sbq.push_back(e);
    for (int i = 1; i <= 26; i++) begin
      tick();
      bus.audio_clk_en = (ev == EV_OVR && i == ev_at);
      if (ev == EV_GATE && i == ev_at) bus.gate = ~bus.gate;
      if (ev == EV_OVR && i >= ev_at - 1 && i <= ev_at + 1) begin
        @(negedge clk);
        chk("overrun_pulse", longint'(bus.overrun), (i == ev_at) ? 1 : 0);
      end
      if (ev == EV_RST && i == ev_at) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midop_reset_v_control", longint'(bus.v_control), sig_low);
        chk("midop_reset_busy", longint'(bus.busy), 0);
        sbq.delete();
        macc = sig_low * 65536;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        return;
      end
    end
    bus.audio_clk_en = 1'b0;
  endtask

  initial begin
    longint v, prev;
    real start, ana;
    int n_tau_c, n_tau_d;

    sig_high = longint'($rtoi(16384.0 * VH_TB / VCC_TB));
    sig_low  = longint'($rtoi(16384.0 * VL_TB / VCC_TB));
    alpha_c  = alpha_of(RC_TB);
    alpha_d  = alpha_of(RD_TB);
    n_tau_c  = $rtoi(RC_TB * C_TB * FS_TB + 0.5);
    n_tau_d  = $rtoi(RD_TB * C_TB * FS_TB + 0.5);

    // Reset held with gate high and strobes running.
    bus.gate = 1'b1;
    bus.audio_clk_en = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.audio_clk_en = (i % 2 == 0);
      @(negedge clk);
      chk("reset_v_control", longint'(bus.v_control), sig_low);
      chk("reset_busy", longint'(bus.busy), 0);
      chk("reset_overrun", longint'(bus.overrun), 0);
    end
    bus.audio_clk_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    macc = sig_low * 65536;

    // Charge from SIG_LOW.
    for (int n = 1; n <= 650; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      strobe(0, EV_NONE);
      if (n == n_tau_c) begin
        v = longint'(bus.v_control);
        ana = real'(sig_high) * (1.0 - $pow(1.0 - real'(alpha_c) / 16777216.0, real'(n)));
        chk("charge_one_tau", ((real'(v) - ana) <= 8.0 && (ana - real'(v)) <= 8.0) ? 1 : 0, 1);
      end
    end
    v = longint'(bus.v_control);
`ifdef RC_RAMP_SNAP_EN
    chk("charge_settled", v, sig_high);
`else
    chk("charge_settled", (v == sig_high || v == sig_high - 1) ? 1 : 0, 1);
`endif

    // Discharge from the settled level.
    bus.gate = 1'b0;
    tick();
    prev = longint'(bus.v_control);
    start = real'(macc) / 65536.0;
    for (int n = 1; n <= 300; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      strobe(0, EV_NONE);
      v = longint'(bus.v_control);
      chk("discharge_monotonic", (v <= prev) ? 1 : 0, 1);
      prev = v;
      if (n == n_tau_d) begin
        ana = start * $pow(1.0 - real'(alpha_d) / 16777216.0, real'(n));
        chk("discharge_one_tau", ((real'(v) - ana) <= 8.0 && (ana - real'(v)) <= 8.0) ? 1 : 0, 1);
      end
    end
    chk("discharge_settled", longint'(bus.v_control), sig_low);

    // Gate falls mid-MUL: this update charges, the next discharges.
    bus.gate = 1'b1;
    tick();
    strobe(5, EV_GATE);
    chk("gate_toggle_charged", (longint'(bus.v_control) > sig_low) ? 1 : 0, 1);
    prev = longint'(bus.v_control);
    tick();
    strobe(0, EV_NONE);
    chk("gate_toggle_then_discharged", (longint'(bus.v_control) < prev) ? 1 : 0, 1);

    // Strobe injected while busy is dropped.
    bus.gate = 1'b1;
    tick();
    strobe(0, EV_NONE);
    strobe(10, EV_OVR);
    strobe(0, EV_NONE);

    // Reset mid-MUL, then a normal sample.
    strobe(12, EV_RST);
    strobe(0, EV_NONE);
    strobe(0, EV_NONE);

    // Random gate pattern.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.gate = ~bus.gate;
        tick();
      end
      repeat ($urandom_range(0, 4)) tick();
      strobe(0, EV_NONE);
    end

    repeat (4) tick();
    chk("scoreboard_drained", longint'(sbq.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rc_ramp_control_voltage.md
# rc_ramp_control_voltage

- Digital model of the RC network that charges and discharges the control-voltage capacitor feeding the 555 VCO's `v_control` input.
- A synchronous `gate` selects one of two target voltages, each with its own time constant.
- The output moves exponentially toward the selected target, one update per audio sample, computed by a serial shift-add multiplier.
- Output uses the codebase's signed 16-bit fixed-point voltage format, where VCC = 1<<SIGNAL_FRACTION_WIDTH.

## Interface
- SIGNAL_FRACTION_WIDTH, 14, VCC maps to 1<<SIGNAL_FRACTION_WIDTH
- VCC, 12.0, supply voltage [V]
- SAMPLE_RATE, 48e3, audio_clk_en rate [Hz]
- V_HIGH, 4.0, target while gate=1 [V]; must stay below 5.0 V
- V_LOW, 0.0, target while gate=0 [V]
- R_CHARGE, 47e3, charge resistor [Ohm]
- R_DISCHARGE, 10e3, discharge resistor [Ohm]
- C, 3.3e-6, capacitor [F]
- SNAP_THRESHOLD, 4, snap window in output LSB (used only with RC_RAMP_SNAP_EN)
- clk  input  1  system clock; sole clock
- I_RSTn  input  1  asynchronous, active-low reset
- audio_clk_en  input  1  one-cycle sample strobe
- gate  input  1  synchronous to clk; 1 = charge toward V_HIGH, 0 = discharge toward V_LOW
- v_control  output  16  signed control voltage
- busy  output  1  multiply/update in progress
- overrun  output  1  one-cycle pulse when a strobe arrives while busy

## Operation
- Constants:
  - SIG_HIGH and SIG_LOW are 16-bit signal values of V_HIGH and V_LOW: SIGNAL_MULTIPLIER*V/VCC, truncated.
  - ALPHA_C and ALPHA_D are 24-bit unsigned: 2^24*(1-exp(-1/(R*C*SAMPLE_RATE))), clamped to 1..2^24-1.
- State:
  - `acc` is a signed 32-bit register holding the voltage with 16 extra fraction bits.
  - v_control = acc[31:16].
  - `gate_q` holds gate registered once.
- FSM states and transitions:
  - IDLE:
    - On audio_clk_en, capture:
      - target = gate_q ? SIG_HIGH : SIG_LOW;
      - alpha = gate_q ? ALPHA_C : ALPHA_D;
      - err = (target<<<16) - acc, held as a 33-bit sign and magnitude.
    - Clear the product accumulator, then go to MUL.
  - MUL:
    - 24 cycles, LSB-first shift-add of the 32-bit |err| by the 24-bit alpha into a 56-bit product.
    - Then go to UPDATE.
  - UPDATE:
    - step = product>>24, truncated toward zero.
    - acc <= acc ± step, using the sign of err.
    - Then go to IDLE.
- `acc` never overshoots the target, because step ≤ |err|.
- A gate change during MUL or UPDATE has no effect until the next sample.
- audio_clk_en in MUL or UPDATE:
  - The sample is dropped and overrun pulses for that cycle.
  - FSM state is unchanged.
  - Cannot occur at 50 MHz / 48 kHz; it exists for verification.
- Reset, asynchronous and possible mid-operation:
  - acc = SIG_LOW<<16, so v_control = SIG_LOW.
  - FSM = IDLE, busy = 0, overrun = 0, gate_q = 0.
  - The product and any in-flight sample are discarded.

## Timing
- Strobe accepted in IDLE at cycle N.
- busy = 1 in cycles N+1..N+25: MUL occupies N+1..N+24, UPDATE is N+25.
- The new v_control is visible at N+26, so latency is 26 clocks.
- The next strobe can be accepted at N+26.
- gate is sampled through gate_q, so a gate edge at cycle M affects strobes at M+1 or later.
- v_control holds between updates. It is registered, with no combinational path from inputs.

## Configuration
- RC_RAMP_SNAP_EN:
  - Defined: in UPDATE, if |target - v_control| ≤ SNAP_THRESHOLD (output LSB), acc <= target<<<16 exactly, replacing the step.
  - Undefined: pure exponential step only. Truncation may leave v_control one LSB short of the target indefinitely.

## Test plan
- Reset with gate=1 and strobes running, then release → v_control=0, busy=0, overrun=0 during reset; first update lands 26 clocks after the first strobe.
- Charge from 0 (defaults, SIG_HIGH=5461):
  - gate=1 for 7445 samples (one tau) → v_control within 3452±8.
  - gate=1 for 149000 samples → v_control ∈ {5460,5461} with the macro undefined; exactly 5461 with RC_RAMP_SNAP_EN.
- Discharge from a settled 5461, gate=0 for 1584 samples → v_control within 2009±8, monotonically non-increasing.
- Gate toggled from 1 to 0 at cycle N+5 of an accepted strobe → that update still charges; the following one discharges.
- Strobe injected at N+10 while busy → overrun is high for exactly that cycle; the sample is dropped, and the update at N+26 matches the single-strobe model.
- I_RSTn asserted at N+12 mid-MUL, then released → v_control=0 immediately, FSM idle; the next strobe is processed normally.
